// File: rtl/fetch_pc_gen.sv
// Purpose : front-end PC generator; presents one aligned fetch group per cycle with slot mask and epoch tag.
// Latency : redirect/predict in cycle N is presented (valid) in cycle N+1; one invalid BOOT cycle after reset.
// Backpr. : group is held stable while fetch_valid_o && !ready_i; redirect/predict discard an unfired group.
//
// Ports:
//   clock_i, reset_n_i          clock, asynchronous active-low reset
//   ready_i                     downstream accepts the presented group
//   redirect_valid_i/pc_i       execute/exception redirect (highest priority, bumps epoch)
//   predict_valid_i/pc_i        fetch2 predicted-taken redirect (epoch unchanged)
//   halt_i                      stop fetching; only a redirect resumes
//   fetch_valid_o, pc_o         request valid, group-aligned address
//   slot_mask_o, epoch_o        wanted-slot mask, redirect epoch of the request
module fetch_pc_gen #(
  parameter int                XLEN        = 32,
  parameter int                FETCH_WIDTH = 2,
  parameter logic [XLEN-1:0]   RESET_PC    = 32'h0,
  parameter int                EPOCH_W     = 2
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   ready_i,
  input  logic                   redirect_valid_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  input  logic                   predict_valid_i,
  input  logic [XLEN-1:0]        predict_pc_i,
  input  logic                   halt_i,
  output logic                   fetch_valid_o,
  output logic [XLEN-1:0]        pc_o,
  output logic [FETCH_WIDTH-1:0] slot_mask_o,
  output logic [EPOCH_W-1:0]     epoch_o
);

  localparam int GB     = 4 * FETCH_WIDTH;
  localparam int LGB    = $clog2(GB);
  localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  localparam logic [XLEN-1:0] GRP_MASK = ~XLEN'(GB - 1);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [XLEN-1:0]      cur_pc, cur_pc_nxt;
  logic [EPOCH_W-1:0]   epoch, epoch_nxt;
  logic [SLOT_W-1:0]    slot_idx;
  logic                 fire;
  logic [XLEN-1:0]      seq_pc;

  // Word index of cur_pc inside its fetch group; a single-slot group has no index bits.
  generate
    if (FETCH_WIDTH > 1) begin : g_slot_idx
      assign slot_idx = cur_pc[LGB-1:2];
    end else begin : g_slot_idx_one
      assign slot_idx = '0;
    end
  endgenerate

  assign fetch_valid_o = (state == RUN);
  assign pc_o          = cur_pc & GRP_MASK;
  assign epoch_o       = epoch;
  assign fire          = fetch_valid_o && ready_i;
  // Wraps modulo 2^XLEN by construction.
  assign seq_pc        = pc_o + XLEN'(GB);

  // Slots before the entry word of an unaligned target are not wanted.
  always_comb begin
    slot_mask_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_mask_o[i] = (SLOT_W'(i) >= slot_idx);
    end
  end

  always_comb begin
    state_nxt  = state;
    cur_pc_nxt = cur_pc;
    epoch_nxt  = epoch;
    if (redirect_valid_i) begin
      // Wins in every state, including HALTED and BOOT.
      state_nxt  = RUN;
      cur_pc_nxt = redirect_pc_i & WORD_MASK;
      epoch_nxt  = epoch + EPOCH_W'(1);
    end else begin
      unique case (state)
        BOOT: begin
          state_nxt = RUN;
        end
        HALTED: begin
          // Hold; predict and halt are ignored here.
        end
        RUN: begin
          if (halt_i) begin
            state_nxt = HALTED;
            if (fire) cur_pc_nxt = seq_pc;
          end else if (predict_valid_i) begin
            // The current group is on the wrong path, so it is dropped even if not fired.
            cur_pc_nxt = predict_pc_i & WORD_MASK;
          end else if (fire) begin
            cur_pc_nxt = seq_pc;
          end
        end
        default: begin
          state_nxt = BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= BOOT;
      cur_pc <= RESET_PC & WORD_MASK;
      epoch  <= '0;
    end else begin
      state  <= state_nxt;
      cur_pc <= cur_pc_nxt;
      epoch  <= epoch_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  m;
    logic [1:0]  e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic        pred_vld;
  logic [31:0] pred_pc;
  logic        halt;
  logic        fetch_vld;
  logic [31:0] pc;
  logic [1:0]  slot_mask;
  logic [1:0]  epoch;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  fetch_pc_gen #(
    .XLEN(32),
    .FETCH_WIDTH(2),
    .RESET_PC(32'h100),
    .EPOCH_W(2)
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .ready_i(ready),
    .redirect_valid_i(redir_vld),
    .redirect_pc_i(redir_pc),
    .predict_valid_i(pred_vld),
    .predict_pc_i(pred_pc),
    .halt_i(halt),
    .fetch_valid_o(fetch_vld),
    .pc_o(pc),
    .slot_mask_o(slot_mask),
    .epoch_o(epoch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic ev, input logic [31:0] epc, input logic [1:0] em, input logic [1:0] ee);
    exp_t x;
    x.v  = ev;
    x.pc = epc;
    x.m  = em;
    x.e  = ee;
    sb_q.push_back(x);
  endtask

  task automatic compare(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_valid"}, {31'd0, fetch_vld}, {31'd0, x.v});
      chk({tag, "_pc"},    pc,                 x.pc);
      chk({tag, "_mask"},  {30'd0, slot_mask}, {30'd0, x.m});
      chk({tag, "_epoch"}, {30'd0, epoch},     {30'd0, x.e});
    end
  endtask

  // Drive one cycle of stimulus, record what must appear after the edge, then compare.
  task automatic step(input string tag,
                      input logic rv, input logic [31:0] rpc,
                      input logic pv, input logic [31:0] ppc,
                      input logic h, input logic rdy,
                      input logic ev, input logic [31:0] epc,
                      input logic [1:0] em, input logic [1:0] ee);
    redir_vld = rv;
    redir_pc  = rpc;
    pred_vld  = pv;
    pred_pc   = ppc;
    halt      = h;
    ready     = rdy;
    push_exp(ev, epc, em, ee);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    ready     = 1'b0;
    redir_vld = 1'b0;
    redir_pc  = '0;
    pred_vld  = 1'b0;
    pred_pc   = '0;
    halt      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0, 32'h100, 2'b11, 2'd0);
    compare("reset");
    #2 rst_n = 1'b1;
    #1;
    push_exp(1'b0, 32'h100, 2'b11, 2'd0);
    compare("boot");

    // Boot -> sequential
    step("run0",   0, 0, 0, 0, 0, 1, 1, 32'h100, 2'b11, 2'd0);
    step("seq1",   0, 0, 0, 0, 0, 1, 1, 32'h108, 2'b11, 2'd0);
    // Backpressure holds the group
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 0, 0, 0, 0, 1, 32'h108, 2'b11, 2'd0);
    step("seq2",   0, 0, 0, 0, 0, 1, 1, 32'h110, 2'b11, 2'd0);

    // Unaligned redirect, then aligned successor
    step("redir_unal", 1, 32'h20C, 0, 0, 0, 0, 1, 32'h208, 2'b10, 2'd1);
    step("redir_seq",  0, 0,       0, 0, 0, 1, 1, 32'h210, 2'b11, 2'd1);

    // Priority: redirect beats predict and halt
    step("prio",       1, 32'h400, 1, 32'h500, 1, 1, 1, 32'h400, 2'b11, 2'd2);
    step("pred_stall", 0, 0,       1, 32'h500, 0, 0, 1, 32'h500, 2'b11, 2'd2);
    step("pred_fire",  0, 0,       1, 32'h50C, 0, 1, 1, 32'h508, 2'b10, 2'd2);

    // Halt with fire, predict ignored while halted, redirect resumes
    step("to_108",     1, 32'h108, 0, 0,       0, 0, 1, 32'h108, 2'b11, 2'd3);
    step("halt_fire",  0, 0,       0, 0,       1, 1, 0, 32'h110, 2'b11, 2'd3);
    step("halt_pred1", 0, 0,       1, 32'h600, 1, 1, 0, 32'h110, 2'b11, 2'd3);
    step("halt_pred2", 0, 0,       1, 32'h700, 0, 1, 0, 32'h110, 2'b11, 2'd3);
    step("resume",     1, 32'h40,  0, 0,       0, 0, 1, 32'h040, 2'b11, 2'd0);

    // Halt without fire keeps pc, then address wrap
    step("halt_nofire", 0, 0,           0, 0, 1, 0, 0, 32'h040,      2'b11, 2'd0);
    step("to_top",      1, 32'hFFFFFFF8, 0, 0, 0, 0, 1, 32'hFFFFFFF8, 2'b11, 2'd1);
    step("wrap",        0, 0,           0, 0, 0, 1, 1, 32'h0,        2'b11, 2'd1);

    // Epoch wraps through four redirects
    step("ep2", 1, 32'h10, 0, 0, 0, 1, 1, 32'h10, 2'b11, 2'd2);
    step("ep3", 1, 32'h14, 0, 0, 0, 1, 1, 32'h10, 2'b10, 2'd3);
    step("ep0", 1, 32'h18, 0, 0, 0, 1, 1, 32'h18, 2'b11, 2'd0);
    step("ep1", 1, 32'h30, 0, 0, 0, 0, 1, 32'h30, 2'b11, 2'd1);
    step("pre_rst_stall", 0, 0, 0, 0, 0, 0, 1, 32'h30, 2'b11, 2'd1);

    // Asynchronous reset mid-stall: outputs change before any edge
    #2 rst_n = 1'b0;
    #1;
    push_exp(1'b0, 32'h100, 2'b11, 2'd0);
    compare("async_rst");
    step("in_rst", 0, 0, 0, 0, 0, 1, 0, 32'h100, 2'b11, 2'd0);
    #2 rst_n = 1'b1;
    step("reboot", 0, 0, 0, 0, 0, 1, 1, 32'h100, 2'b11, 2'd0);
    step("reseq",  0, 0, 0, 0, 0, 1, 1, 32'h108, 2'b11, 2'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Parametrised front-end PC generator; the successor to the fixed +8 fetch1 PC stage.
- Each cycle it produces an aligned fetch-group address for the instruction memory, plus a per-slot valid mask and a redirect epoch tag.
- Adds an instruction-memory valid/ready handshake, backpressure, predictor and execute redirects, a boot cycle and halt.
- Sits ahead of the imem buffer and feeds fetch2.

Parameters:
- XLEN, 32, address width.
- FETCH_WIDTH, 2, instructions per fetch group. Must be a power of two, 1..8.
- RESET_PC, 32'h0, address fetched first after reset.
- EPOCH_W, 2, width of the redirect epoch counter.

Ports:
- clock_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- ready_i  in  1  downstream (imem buffer) accepts the current group this cycle.
- redirect_valid_i  in  1  execute/exception redirect; highest priority.
- redirect_pc_i  in  XLEN  redirect target.
- predict_valid_i  in  1  fetch2 predicted-taken redirect.
- predict_pc_i  in  XLEN  predicted target.
- halt_i  in  1  stop fetching after the current cycle.
- fetch_valid_o  out  1  pc_o/slot_mask_o/epoch_o describe a real request.
- pc_o  out  XLEN  fetch-group address, aligned to GB = 4*FETCH_WIDTH bytes.
- slot_mask_o  out  FETCH_WIDTH  bit i set means slot i holds a wanted instruction.
- epoch_o  out  EPOCH_W  epoch tag of the current request.

Behaviour:
- Internal registers:
  - cur_pc, XLEN bits; bits [1:0] are always 0.
  - state, one of BOOT, RUN, HALTED.
  - epoch counter.
- Targets: the low two bits of any redirect or predict target are forced to 0 when captured.
- Combinational outputs:
  - pc_o = cur_pc & ~(GB-1).
  - slot_mask_o bit i = (i >= cur_pc[log2(GB)-1:2]).
  - fetch_valid_o = (state == RUN).
- Reset (async, reset_n_i low): cur_pc = RESET_PC with low bits cleared, state = BOOT, epoch = 0. So fetch_valid_o = 0, pc_o = aligned RESET_PC, slot_mask_o derived from RESET_PC.
- Fire: fetch_valid_o && ready_i.
- Next-state priority, evaluated each posedge:
  1. redirect_valid_i, any state: cur_pc <= target, epoch <= epoch+1 (wraps mod 2^EPOCH_W), state <= RUN. Overrides halt_i, predict and stall; the currently presented group is dropped even if not fired.
  2. state == BOOT: state <= RUN; cur_pc unchanged. Exactly one invalid cycle after reset release.
  3. state == HALTED: hold everything. predict_valid_i and halt_i are ignored. Only a redirect exits.
  4. state == RUN and halt_i: state <= HALTED; cur_pc <= sequential successor if fired, else unchanged.
  5. state == RUN and predict_valid_i: cur_pc <= target, epoch unchanged, regardless of ready_i. The unfired current group is discarded because it is on the wrong path.
  6. state == RUN and fire: cur_pc <= pc_o + GB. The sequential successor is always group-aligned, so the next mask is all ones.
  7. Otherwise (RUN, not fired): hold cur_pc. Outputs stay stable while valid && !ready.
- Address arithmetic: pc_o + GB is modulo 2^XLEN; the all-ones group wraps to 0 with no flag.
- Latency: a redirect or predict in cycle N is presented in cycle N+1 with valid, given state RUN or a redirect. There is no bubble beyond the one BOOT cycle.
- Reset mid-operation: takes effect immediately, asynchronously. Outputs take their reset values without waiting for a clock edge.
- ready_i is a don't-care when fetch_valid_o = 0.

Test Plan:
- Boot/sequential (FETCH_WIDTH=2, RESET_PC=0x100, ready=1):
  - Release reset: one cycle valid=0, pc=0x100.
  - Then valid pcs 0x100, 0x108, 0x110, each with mask 2'b11, epoch 0.
- Backpressure: ready=0 for 3 cycles at pc 0x108 -> pc/mask/epoch held, valid=1 throughout; ready=1 -> next cycle pc=0x110.
- Unaligned redirect: redirect to 0x20C (FETCH_WIDTH=2) -> next cycle pc=0x208, mask=2'b10, epoch=1; following cycle pc=0x210, mask=2'b11.
- Priority:
  - Redirect 0x400 plus predict 0x500 plus halt in the same cycle -> pc=0x400, RUN, epoch+1.
  - Predict alone to 0x500 while ready=0 -> pc=0x500, epoch unchanged.
- Halt/resume:
  - halt_i with fire at 0x108 -> valid=0, held pc=0x110; predict pulses ignored.
  - Redirect 0x40 -> valid=1, pc=0x40, epoch incremented.
- Wrap/epoch/reset:
  - pc 0xFFFFFFF8 fired -> pc=0x0.
  - Four redirects -> epoch wraps 3->0.
  - Drop reset_n_i mid-stall -> outputs return immediately to boot values.
